// File: rtl/add_pipe_pkg.sv
// add_pipe_pkg: shared definitions for the pipelined adder/subtractor.
//   op_e        - operation encoding on op_sub (OP_ADD / OP_SUB).
//   split_legal - elaboration-time check that a WIDTH/CHUNK split is buildable.
package add_pipe_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // WIDTH must divide into CHUNK slices, and CHUNK must divide into 4-bit
  // lookahead groups. At least two stages are needed for the skew chain.
  function automatic logic split_legal(input int width, input int chunk);
    return (chunk >= 4) && ((chunk % 4) == 0) && ((width % chunk) == 0) &&
           ((width / chunk) >= 2);
  endfunction

endpackage

// File: rtl/add_pipe_if.sv
// add_pipe_if: operand/result handshake bundle for add_pipe.
//   master - producer/consumer side (drives operands and out_ready).
//   slave  - the adder (drives in_ready and the result).
interface add_pipe_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             op_sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, op_sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, op_sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/add_pipe_cla_chunk.sv
// cla_chunk: combinational W-bit carry-lookahead adder built from 4-bit
// lookahead groups with a group-level lookahead on top.
//   a, b, cin - operands and carry-in
//   sum, cout - W-bit result and carry out of the MSB
//   c_msb_in  - carry into the MSB (for signed overflow)
//   grp_g/p   - block generate/propagate of the whole slice
module cla_chunk #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb_in,
  output logic         grp_g,
  output logic         grp_p
);
  localparam int NG = W / 4;

  logic [W-1:0]  gen_s;
  logic [W-1:0]  prop_s;
  logic [W-1:0]  carry_s;
  logic [NG-1:0] gg_s;
  logic [NG-1:0] gp_s;
  logic [NG:0]   gc_s;

  // Bit generate/propagate and 4-bit group generate/propagate terms.
  always_comb begin
    gen_s  = a & b;
    prop_s = a ^ b;
    gg_s   = '0;
    gp_s   = '0;
    for (int g = 0; g < NG; g++) begin
      gg_s[g] = gen_s[4*g+3]
              | (prop_s[4*g+3] & gen_s[4*g+2])
              | (prop_s[4*g+3] & prop_s[4*g+2] & gen_s[4*g+1])
              | (prop_s[4*g+3] & prop_s[4*g+2] & prop_s[4*g+1] & gen_s[4*g]);
      gp_s[g] = &prop_s[4*g+3 -: 4];
    end
  end

  // Group-level lookahead: carry into each group plus the slice-wide G/P.
  always_comb begin
    gc_s    = '0;
    gc_s[0] = cin;
    grp_g   = gg_s[0];
    grp_p   = gp_s[0];
    for (int g = 0; g < NG; g++) begin
      gc_s[g+1] = gg_s[g] | (gp_s[g] & gc_s[g]);
    end
    for (int g = 1; g < NG; g++) begin
      grp_g = gg_s[g] | (gp_s[g] & grp_g);
      grp_p = gp_s[g] & grp_p;
    end
  end

  // Per-bit carries inside each group, expanded so no carry ripples within a group.
  always_comb begin
    carry_s = '0;
    for (int g = 0; g < NG; g++) begin
      carry_s[4*g]   = gc_s[g];
      carry_s[4*g+1] = gen_s[4*g] | (prop_s[4*g] & gc_s[g]);
      carry_s[4*g+2] = gen_s[4*g+1]
                     | (prop_s[4*g+1] & gen_s[4*g])
                     | (prop_s[4*g+1] & prop_s[4*g] & gc_s[g]);
      carry_s[4*g+3] = gen_s[4*g+2]
                     | (prop_s[4*g+2] & gen_s[4*g+1])
                     | (prop_s[4*g+2] & prop_s[4*g+1] & gen_s[4*g])
                     | (prop_s[4*g+2] & prop_s[4*g+1] & prop_s[4*g] & gc_s[g]);
    end
    sum      = prop_s ^ carry_s;
    cout     = gc_s[NG];
    c_msb_in = carry_s[W-1];
  end

endmodule

// File: rtl/add_pipe.sv
// add_pipe: pipelined adder/subtractor resolving one CHUNK-bit slice per stage.
//   clk, rst - clock and asynchronous active-high reset
//   bus      - add_pipe_if.slave: in_valid/in_ready/a/b/op_sub/cin in,
//              out_valid/out_ready/sum/cout/ovf/zero out
// Latency is NSTG cycles; one operation per cycle while the output drains.
module add_pipe
  import add_pipe_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic      clk,
  input  logic      rst,
  add_pipe_if.slave bus
);
  localparam int NSTG = WIDTH / CHUNK;

  if (!split_legal(WIDTH, CHUNK)) begin : g_bad_split
    $error("add_pipe: illegal WIDTH/CHUNK split");
  end

  logic             en_s;
  logic [WIDTH-1:0] b_cond_s;
  logic             c0_s;

  // Operands still to be added are kept right-justified, so every stage adds
  // bits [CHUNK-1:0] of its source and shifts the rest down by one slice.
  // Finished slices enter the result at the top and shift down, so after the
  // last stage slice 0 sits at the bottom.
  logic [WIDTH-1:0] a_skew_r [NSTG];
  logic [WIDTH-1:0] b_skew_r [NSTG];
  logic [WIDTH-1:0] res_r    [NSTG];
  logic [NSTG-1:0]  valid_r;
  logic [NSTG-1:0]  carry_r;
  logic [NSTG-1:0]  zero_r;
  logic             ovf_r;

  logic [WIDTH-1:0] src_a_s   [NSTG];
  logic [WIDTH-1:0] src_b_s   [NSTG];
  logic [WIDTH-1:0] src_res_s [NSTG];
  logic [NSTG-1:0]  src_c_s;
  logic [NSTG-1:0]  src_z_s;
  logic [NSTG-1:0]  src_v_s;

  logic [CHUNK-1:0] stage_sum_s [NSTG];
  logic [NSTG-1:0]  stage_cout_s;
  logic [NSTG-1:0]  stage_cmsb_s;
  logic [NSTG-1:0]  stage_g_s;
  logic [NSTG-1:0]  stage_p_s;

  // Stall only when a result is waiting and nobody takes it.
  always_comb begin
    en_s = !(valid_r[NSTG-1] && !bus.out_ready);
  end

  // Subtraction is A + ~B + 1; cin then acts as borrow-in.
  always_comb begin
    if (bus.op_sub == OP_SUB) begin
      b_cond_s = ~bus.b;
    end else begin
      b_cond_s = bus.b;
    end
    c0_s = bus.cin ^ bus.op_sub;
  end

  // Stage sources: stage 0 takes the conditioned inputs, later stages the previous stage.
  always_comb begin
    src_a_s[0]   = bus.a;
    src_b_s[0]   = b_cond_s;
    src_res_s[0] = '0;
    src_c_s      = '0;
    src_z_s      = '0;
    src_v_s      = '0;
    src_c_s[0]   = c0_s;
    src_z_s[0]   = 1'b1;
    src_v_s[0]   = bus.in_valid;
    for (int k = 1; k < NSTG; k++) begin
      src_a_s[k]   = a_skew_r[k-1];
      src_b_s[k]   = b_skew_r[k-1];
      src_res_s[k] = res_r[k-1];
      src_c_s[k]   = carry_r[k-1];
      src_z_s[k]   = zero_r[k-1];
      src_v_s[k]   = valid_r[k-1];
    end
  end

  for (genvar k = 0; k < NSTG; k++) begin : g_stage
    cla_chunk #(.W(CHUNK)) u_cla (
      .a        (src_a_s[k][CHUNK-1:0]),
      .b        (src_b_s[k][CHUNK-1:0]),
      .cin      (src_c_s[k]),
      .sum      (stage_sum_s[k]),
      .cout     (stage_cout_s[k]),
      .c_msb_in (stage_cmsb_s[k]),
      .grp_g    (stage_g_s[k]),
      .grp_p    (stage_p_s[k])
    );
  end

  // Advance every stage register together; everything holds during a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= '0;
      carry_r <= '0;
      zero_r  <= '0;
      ovf_r   <= 1'b0;
      for (int k = 0; k < NSTG; k++) begin
        a_skew_r[k] <= '0;
        b_skew_r[k] <= '0;
        res_r[k]    <= '0;
      end
    end else if (en_s) begin
      valid_r <= src_v_s;
      // Only the top slice's carries describe signed overflow of the full word.
      ovf_r   <= stage_cmsb_s[NSTG-1] ^ stage_cout_s[NSTG-1];
      for (int k = 0; k < NSTG; k++) begin
        a_skew_r[k] <= src_a_s[k] >> CHUNK;
        b_skew_r[k] <= src_b_s[k] >> CHUNK;
        res_r[k]    <= {stage_sum_s[k], src_res_s[k][WIDTH-1:CHUNK]};
        // Carry mux: the slice carry-out from its block generate/propagate.
        carry_r[k]  <= stage_g_s[k] | (stage_p_s[k] & src_c_s[k]);
        zero_r[k]   <= src_z_s[k] & (stage_sum_s[k] == '0);
      end
    end
  end

  assign bus.in_ready  = en_s;
  assign bus.out_valid = valid_r[NSTG-1];
  assign bus.sum       = res_r[NSTG-1];
  assign bus.cout      = carry_r[NSTG-1];
  assign bus.ovf       = ovf_r;
  assign bus.zero      = zero_r[NSTG-1];

endmodule

// File: tb/tb_add_pipe.sv
// tb_add_pipe: directed self-checking bench for add_pipe (64/16 and 32/8 builds).
module tb_add_pipe;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  add_pipe_if #(.WIDTH(64)) bus64 ();
  add_pipe_if #(.WIDTH(32)) bus32 ();

  add_pipe #(.WIDTH(64), .CHUNK(16)) u_dut64 (.clk(clk), .rst(rst), .bus(bus64));
  add_pipe #(.WIDTH(32), .CHUNK(8))  u_dut32 (.clk(clk), .rst(rst), .bus(bus32));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated 64-bit operation: latency and all result fields.
  task automatic run64(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic op, input logic ci, input logic [63:0] esum,
                       input logic ecout, input logic eovf, input logic ezero);
    int lat;
    bus64.a = a; bus64.b = b; bus64.op_sub = op; bus64.cin = ci;
    bus64.in_valid = 1'b1; bus64.out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, 64'(bus64.in_ready), 64'd1);
    tick();
    bus64.in_valid = 1'b0;
    lat = 1;
    while (!bus64.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd4);
    check({tag, "_sum"}, bus64.sum, esum);
    check({tag, "_cout"}, 64'(bus64.cout), 64'(ecout));
    check({tag, "_ovf"}, 64'(bus64.ovf), 64'(eovf));
    check({tag, "_zero"}, 64'(bus64.zero), 64'(ezero));
    tick();
    check({tag, "_drained"}, 64'(bus64.out_valid), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ta [8];
    logic [63:0] tbv [8];
    logic [63:0] texp [8];
    logic [63:0] held_sum;
    logic        stall_prev;
    logic        accept;
    int          tx;
    int          rx;
    int          lat;
    int          seen;

    rst = 1'b1;
    bus64.in_valid = 1'b0; bus64.a = '0; bus64.b = '0; bus64.op_sub = 1'b0;
    bus64.cin = 1'b0; bus64.out_ready = 1'b1;
    bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.op_sub = 1'b0;
    bus32.cin = 1'b0; bus32.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_out_valid", 64'(bus64.out_valid), 64'd0);
    check("rst_sum", bus64.sum, 64'd0);
    check("rst_cout", 64'(bus64.cout), 64'd0);
    check("rst_ovf", 64'(bus64.ovf), 64'd0);
    check("rst_zero", 64'(bus64.zero), 64'd0);
    check("rst_in_ready", 64'(bus64.in_ready), 64'd1);
    check("rst32_out_valid", 64'(bus32.out_valid), 64'd0);

    // Directed arithmetic cases
    run64("add_ffff", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0,
          64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0);
    run64("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
          64'h0000_0000_0000_0000, 1'b1, 1'b0, 1'b1);
    run64("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0,
          64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
    run64("sub_borrow", 64'd5, 64'd5, 1'b1, 1'b1,
          64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
    run64("add_cin", 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b1,
          64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);

    // 32/8 build: carry ripples across all four byte stages
    bus32.a = 32'h00FF_FFFF; bus32.b = 32'd1; bus32.op_sub = 1'b0; bus32.cin = 1'b0;
    bus32.in_valid = 1'b1; bus32.out_ready = 1'b1;
    tick();
    bus32.in_valid = 1'b0;
    lat = 1;
    while (!bus32.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("w32_latency", 64'(lat), 64'd4);
    check("w32_sum", 64'(bus32.sum), 64'h0000_0000_0100_0000);
    check("w32_cout", 64'(bus32.cout), 64'd0);
    check("w32_zero", 64'(bus32.zero), 64'd0);
    tick();

    // Back-to-back tokens with out_ready alternating 1,0,1,0...
    for (int i = 0; i < 8; i++) begin
      ta[i]   = 64'h0000_FFFF_FFFF_FFF0 + 64'(i);
      tbv[i]  = 64'(i) * 64'h0001_0000_0001_0011;
      texp[i] = ta[i] + tbv[i];
    end
    tx = 0; rx = 0; stall_prev = 1'b0; held_sum = '0;
    bus64.op_sub = 1'b0; bus64.cin = 1'b0;
    for (int cyc = 0; cyc < 200 && rx < 8; cyc++) begin
      bus64.out_ready = ((cyc % 2) == 0);
      if (tx < 8) begin
        bus64.in_valid = 1'b1;
        bus64.a = ta[tx];
        bus64.b = tbv[tx];
      end else begin
        bus64.in_valid = 1'b0;
      end
      #1;
      check("b2b_in_ready", 64'(bus64.in_ready),
            64'(!(bus64.out_valid && !bus64.out_ready)));
      if (stall_prev) begin
        check("b2b_hold_valid", 64'(bus64.out_valid), 64'd1);
        check("b2b_hold_sum", bus64.sum, held_sum);
      end
      stall_prev = bus64.out_valid && !bus64.out_ready;
      held_sum   = bus64.sum;
      if (bus64.out_valid && bus64.out_ready) begin
        check("b2b_sum", bus64.sum, texp[rx]);
        rx++;
      end
      accept = bus64.in_valid && bus64.in_ready;
      tick();
      if (accept) tx++;
    end
    bus64.in_valid = 1'b0;
    bus64.out_ready = 1'b1;
    check("b2b_count", 64'(rx), 64'd8);
    seen = 0;
    repeat (6) begin
      tick();
      if (bus64.out_valid) seen++;
    end
    check("b2b_no_extra", 64'(seen), 64'd0);

    // Asynchronous reset with tokens in flight
    bus64.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus64.in_valid = 1'b1;
      bus64.a = 64'(i + 1);
      bus64.b = 64'd0;
      tick();
    end
    bus64.in_valid = 1'b0;
    bus64.out_ready = 1'b0;
    tick();
    check("arst_pre_valid", 64'(bus64.out_valid), 64'd1);
    check("arst_pre_sum", bus64.sum, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid_drop", 64'(bus64.out_valid), 64'd0);
    check("arst_sum_clear", bus64.sum, 64'd0);
    #1;
    rst = 1'b0;
    bus64.out_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      tick();
      if (bus64.out_valid) seen++;
    end
    check("arst_no_result", 64'(seen), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/add_pipe.md
# add_pipe

Parametrised, pipelined carry-lookahead adder/subtractor that supersedes the fixed 64-bit combinational adder. Operands are split into CHUNK-bit slices, and one slice is resolved per pipeline stage, so the critical path is one CHUNK-wide lookahead add rather than the full WIDTH. It sits in front of the multiplier/ALU datapath. It has a valid/ready handshake on both sides and accepts one operation per cycle.

## Interface
Parameters:
- WIDTH, 64, operand/result width; must be a multiple of CHUNK.
- CHUNK, 16, slice width per stage; must be a multiple of 4.
- NSTG, WIDTH/CHUNK (derived localparam), pipeline depth and latency.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand token present.
- in_ready  out  1  block can accept the token this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op_sub  in  1  0 = A+B, 1 = A−B.
- cin  in  1  carry-in (add) or borrow-in (sub).
- out_valid  out  1  result token present.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB (for sub: 1 = no borrow).
- ovf  out  1  signed overflow.
- zero  out  1  sum == 0.

## Operation
- Operand conditioning at stage 0: B' = op_sub ? ~b : b; carry-in c0 = cin ^ op_sub.
- Stage k (0..NSTG−1) adds slice k of A and B' with the carry registered from stage k−1 (c0 for k=0). The slice result, carry, and slice-zero bit are registered.
- Higher slices (index > k) travel unmodified in skew registers. Completed lower slices travel in de-skew registers. All are aligned at the output.
- zero = AND of all per-slice zero bits, accumulated along the pipe.
- ovf = carry into MSB XOR carry out of MSB, taken from the last slice.
- Arithmetic is modulo 2^WIDTH. No saturation.
- Each stage holds a valid bit. Bubbles propagate as valid=0.
- Global advance enable: en = !(out_valid && !out_ready).
- When en=0, every stage register holds its value.
- in_ready = en. A token is accepted when in_valid && in_ready at the rising edge.
- Reset state: all valid bits 0 and all data registers 0, so out_valid=0, sum=0, cout=0, ovf=0, zero=0, in_ready=1.
- Reset asserted mid-operation: all in-flight tokens are discarded immediately (asynchronously). No result for them ever appears.

## Timing
- Latency: a token accepted at edge t is presented with out_valid=1 after edge t+NSTG−1, i.e. visible during cycle t+NSTG.
- Throughput: one token per cycle while out_ready=1.
- While out_valid && !out_ready: sum/cout/ovf/zero are stable, and in_ready=0.
- out_valid=1 and out_ready=1 in the same cycle as a new acceptance: both transfers complete and the pipe advances.
- Bubble at the output (out_valid=0): the pipe advances regardless of out_ready.
- Token order is strictly preserved.
- No combinational path from in_valid/a/b to any output.
- in_ready depends combinationally only on out_valid and out_ready.
- The critical path is one CHUNK-bit lookahead add plus the carry mux.

## Structure
- Shared header/package add_defs: operation encoding (OP_ADD=0, OP_SUB=1) and the WIDTH % CHUNK and CHUNK % 4 legality checks, reused by the multiplier.
- Sub-module cla_chunk:
  - Parameter W (=CHUNK).
  - Inputs a, b, cin. Outputs sum, cout, c_msb_in (carry into its MSB), G, P.
  - Combinational: 4-bit lookahead groups with a group-level lookahead.
- add_pipe contains a generate loop of NSTG cla_chunk instances plus the skew/de-skew/valid registers.

## Test plan
- Defaults, add, a=0x0000_0000_0000_FFFF, b=1, cin=0 → sum=0x0000_0000_0001_0000, cout=0, ovf=0, zero=0; out_valid rises exactly 4 cycles after acceptance.
- Add, a=0xFFFF_FFFF_FFFF_FFFF, b=1 → sum=0, cout=1, zero=1, ovf=0. The carry must ripple through all 4 stages.
- Sub, a=0x8000_0000_0000_0000, b=1, cin=0 → sum=0x7FFF_FFFF_FFFF_FFFF, ovf=1, cout=1.
- Sub, a=5, b=5, cin=1 → sum=0xFFFF_FFFF_FFFF_FFFF, cout=0, zero=0.
- 8 back-to-back tokens with out_ready toggling 1,0,1,0…:
  - all 8 results arrive in order, none lost or duplicated;
  - outputs are stable during each stall;
  - in_ready=0 exactly when out_valid && !out_ready.
- rst pulsed with 3 tokens in flight → out_valid drops to 0 without waiting for a clock edge, and no result appears after release.
- Repeat the carry-ripple case with WIDTH=32, CHUNK=8: 0x00FF_FFFF+1 → 0x0100_0000, latency 4.
